mul_controller: RTL and testbench

MUL_CONTROLLER -- requirements
Module: mul_controller

---
 rtl/mul_controller.sv | 127 ++++++++++++
 tb/tb_mul_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mul_controller.sv
// Control FSM for a shift-free repeated-add multiplier (P += A, B -= 1 until B == 0).
//
// Ports
//   clk        : clock, all state changes on rising edge
//   rst        : synchronous active-high reset
//   start      : request one multiply (sampled only in S_IDLE)
//   abort      : synchronous cancel of any operation in progress
//   done       : datapath flag, 1 when the B register is 0
//   lda, ldb   : load A / load B
//   ldp, clrp  : accumulate P / clear P
//   decb       : decrement B
//   busy       : high in every state except S_IDLE
//   prod_valid : one-cycle pulse, datapath product valid
//   err        : one-cycle pulse after a timeout abort
//   iter_cnt   : accumulate cycles issued in the current or last operation
module mul_controller #(
   parameter int unsigned TIMEOUT = 300,
   parameter int unsigned CNT_W   = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       done,
   output logic       lda,
   output logic       ldb,
   output logic       ldp,
   output logic       clrp,
   output logic       decb,
   output logic       busy,
   output logic       prod_valid,
   output logic       err,
   output logic [7:0] iter_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_LDA, S_LDB, S_ADD, S_DONE} state_t;

   localparam logic [CNT_W-1:0] AddLast = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] add_cnt;

   // Accumulate and decrement follow done directly so the add loop runs
   // exactly B cycles without a pipeline bubble.
   assign ldp  = (state == S_ADD) & ~done;
   assign decb = (state == S_ADD) & ~done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         add_cnt    <= '0;
         iter_cnt   <= '0;
         lda        <= 1'b0;
         ldb        <= 1'b0;
         clrp       <= 1'b0;
         busy       <= 1'b0;
         prod_valid <= 1'b0;
         err        <= 1'b0;
      end else begin
         // Registered outputs are pulses unless re-asserted by the next state.
         lda        <= 1'b0;
         ldb        <= 1'b0;
         clrp       <= 1'b0;
         prod_valid <= 1'b0;
         err        <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  state    <= S_LDA;
                  iter_cnt <= '0;
                  lda      <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            S_LDA: begin
               if (abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= S_LDB;
                  ldb   <= 1'b1;
                  clrp  <= 1'b1;
               end
            end
            S_LDB: begin
               if (abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state   <= S_ADD;
                  add_cnt <= '0;
               end
            end
            S_ADD: begin
               if (abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (done) begin
                  state      <= S_DONE;
                  prod_valid <= 1'b1;
               end else begin
                  if (iter_cnt != 8'hff) begin
                     iter_cnt <= iter_cnt + 8'd1;
                  end
                  // add_cnt counts cycles already spent in S_ADD; this is the last allowed one.
                  if (add_cnt == AddLast) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                     err   <= 1'b1;
                  end else begin
                     add_cnt <= add_cnt + 1'b1;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_controller.sv
// Self-checking bench for mul_controller with a behavioural A/B/P datapath.
module tb_mul_controller;

   logic       clk, rst, start, abort, done;
   logic       lda, ldb, ldp, clrp, decb, busy, prod_valid, err;
   logic [7:0] iter_cnt;

   logic [7:0] a_in, b_in, a_reg, b_reg, p_reg;
   logic       force_done0;

   int n_checks = 0;
   int n_fail   = 0;

   mul_controller #(.TIMEOUT(300), .CNT_W(9)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .done(done),
      .lda(lda), .ldb(ldb), .ldp(ldp), .clrp(clrp), .decb(decb),
      .busy(busy), .prod_valid(prod_valid), .err(err), .iter_cnt(iter_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath model
   assign done = force_done0 ? 1'b0 : (b_reg == 8'd0);
   always_ff @(posedge clk) begin
      if (lda) a_reg <= a_in;
      if (ldb) b_reg <= b_in;
      else if (decb) b_reg <= b_reg - 8'd1;
      if (clrp) p_reg <= 8'd0;
      else if (ldp) p_reg <= p_reg + a_reg;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Control exclusivity: clrp only alongside ldb, ldp only with decb.
   always @(negedge clk) begin
      if (!rst) begin
         chk("ctl_exclusive", {31'd0, (clrp & (lda | ldp | decb)) | (ldp & ~decb)}, 32'd0);
      end
   end

   // Launch one op; e counts cycles after the start-sampling edge (e=1 is S_LDA).
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int inj_start,
                         input int abort_at, input int max_e,
                         output int lat, output int idle_at, output int err_at,
                         output int nldp, output int npv);
      a_in = a;
      b_in = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0; idle_at = 0; err_at = 0; nldp = 0; npv = 0;
      for (int e = 1; e <= max_e; e++) begin
         start = (e == inj_start);
         abort = (e == abort_at);
         if (e == 1) chk("lda_phase", {27'd0, lda, ldb, clrp, ldp, decb}, 32'h10);
         if (e == 2 && abort_at != 1) chk("ldb_phase", {27'd0, lda, ldb, clrp, ldp, decb}, 32'h0c);
         if (ldp) nldp++;
         if (prod_valid) begin
            npv++;
            if (lat == 0) lat = e;
         end
         if (err && err_at == 0) err_at = e;
         if (!busy && idle_at == 0) idle_at = e;
         if (idle_at != 0 && e >= idle_at + 2) break;
         tick();
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      int         inj;
      logic [7:0] prod;
      int         lat;
   } vec_t;

   vec_t vecs[5];
   int lat, idle_at, err_at, nldp, npv, bad;

   initial begin
      vecs[0] = '{a: 8'd5,   b: 8'd3,   inj: 0, prod: 8'd15,  lat: 7};
      vecs[1] = '{a: 8'd9,   b: 8'd0,   inj: 0, prod: 8'd0,   lat: 4};
      vecs[2] = '{a: 8'd255, b: 8'd2,   inj: 0, prod: 8'd254, lat: 6};
      vecs[3] = '{a: 8'd255, b: 8'd255, inj: 0, prod: 8'd1,   lat: 259};
      vecs[4] = '{a: 8'd7,   b: 8'd4,   inj: 5, prod: 8'd28,  lat: 8};

      rst = 1'b1; start = 1'b0; abort = 1'b0; force_done0 = 1'b0;
      a_in = 8'd0; b_in = 8'd0;
      tick(); tick();
      chk("reset_ctl", {24'd0, lda, ldb, ldp, clrp, decb, busy, prod_valid, err}, 32'd0);
      chk("reset_iter", {24'd0, iter_cnt}, 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].inj, 0, 400, lat, idle_at, err_at, nldp, npv);
         chk($sformatf("v%0d_prod", i), {24'd0, p_reg}, {24'd0, vecs[i].prod});
         chk($sformatf("v%0d_iter", i), {24'd0, iter_cnt}, {24'd0, vecs[i].b});
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_idle", i), idle_at, vecs[i].lat + 1);
         chk($sformatf("v%0d_ldp_cycles", i), nldp, {24'd0, vecs[i].b});
         chk($sformatf("v%0d_pv_count", i), npv, 1);
         chk($sformatf("v%0d_err", i), err_at, 0);
         tick();
      end

      // Abort in cycle 5 of 6*10, then a clean 2*3.
      run_op(8'd6, 8'd10, 0, 5, 20, lat, idle_at, err_at, nldp, npv);
      chk("abort_idle", idle_at, 6);
      chk("abort_pv", npv, 0);
      chk("abort_err", err_at, 0);
      chk("abort_iter_hold", {24'd0, iter_cnt}, 32'd2);
      chk("abort_ctl", {27'd0, lda, ldb, clrp, ldp, decb}, 32'd0);
      run_op(8'd2, 8'd3, 0, 0, 40, lat, idle_at, err_at, nldp, npv);
      chk("post_abort_prod", {24'd0, p_reg}, 32'd6);
      chk("post_abort_pv", npv, 1);

      // Abort beats start in S_IDLE.
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("idle_abort_busy", {31'd0, busy}, 32'd0);
      chk("idle_abort_lda", {31'd0, lda}, 32'd0);
      tick();

      // Timeout: 300 cycles in S_ADD (cycles 3..302), err in cycle 303.
      force_done0 = 1'b1;
      run_op(8'd3, 8'd1, 0, 0, 320, lat, idle_at, err_at, nldp, npv);
      chk("to_err_cycle", err_at, 303);
      chk("to_idle_cycle", idle_at, 303);
      chk("to_pv", npv, 0);
      chk("to_ldp_cycles", nldp, 300);
      chk("to_iter_sat", {24'd0, iter_cnt}, 32'd255);
      chk("to_err_pulse", {31'd0, err}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("to_reset_ctl", {24'd0, lda, ldb, ldp, clrp, decb, busy, prod_valid, err}, 32'd0);
      chk("to_reset_iter", {24'd0, iter_cnt}, 32'd0);
      tick();

      // Abort coinciding with the timeout cycle suppresses err.
      run_op(8'd3, 8'd1, 0, 302, 320, lat, idle_at, err_at, nldp, npv);
      chk("to_abort_err", err_at, 0);
      chk("to_abort_idle", idle_at, 303);
      force_done0 = 1'b0;
      tick();

      // Reset in the middle of an operation drops it silently.
      a_in = 8'd4; b_in = 8'd5; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_ldp", {31'd0, ldp}, 32'd0);
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         if (prod_valid || err || busy) bad++;
         tick();
      end
      chk("midrst_silent", bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
